// File: rtl/rf_pkg.sv
// rf_pkg: shared state encoding and default sizes for the parameterised register file
package rf_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_e;
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam logic [RF_DATA_W-1:0] RF_ZERO = '0;
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: walks a pointer over every register, issuing one zero-write per cycle
module rf_clear_seq import rf_pkg::*; #(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    if (state_q == RF_IDLE) begin
      state_d = start ? RF_CLEAR : RF_IDLE;
      ptr_d   = start ? '0 : ptr_q;
      busy_d  = start;
    end else begin
      ptr_d   = ptr_q + 1'b1;
      state_d = &ptr_q ? RF_IDLE : RF_CLEAR;
      busy_d  = ~&ptr_q;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end
  assign busy     = busy_q;
  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = ptr_q;
endmodule

// File: rtl/param_register_file.sv
// param_register_file: 2R1W register file with optional bypass, hardwired zero reg and clear sequencer
module param_register_file import rf_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] input_reg_readA_address,
  input  logic [ADDR_W-1:0] input_reg_readB_address,
  input  logic              input_reg_write,
  input  logic [ADDR_W-1:0] input_reg_write_address,
  input  logic [DATA_W-1:0] input_reg_write_value,
  input  logic              input_clear_start,
  output logic [DATA_W-1:0] output_reg_A,
  output logic [DATA_W-1:0] output_reg_B,
  output logic              output_busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  rf_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (input_clear_start),
    .busy     (output_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
  // Masking the write at address 0 here also keeps it out of the bypass path
  always_comb begin
    wa    = clr_we ? clr_addr : input_reg_write_address;
    wd    = clr_we ? DATA_W'(RF_ZERO) : input_reg_write_value;
    we    = (clr_we | input_reg_write) & ~((ZERO_REG != 0) && wa == '0);
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
    a_d = ((BYPASS != 0) && we && wa == input_reg_readA_address) ? wd : mem_q[input_reg_readA_address];
    b_d = ((BYPASS != 0) && we && wa == input_reg_readB_address) ? wd : mem_q[input_reg_readB_address];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      mem_q <= mem_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end
  assign output_reg_A = a_q;
  assign output_reg_B = b_q;
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Next-generation programmable register file for the 16-bit multi-cycle datapath.
- Width and depth are set by parameters. It has two registered read ports and one write port.
- Adds optional write-to-read bypass, an optional hardwired-zero register 0, and a multi-cycle clear sequencer.
- Sits between the control FSM and the ALU operand latches.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (derived localparam, not overridable).
- BYPASS, 1, 1: a same-cycle write to the addressed register is forwarded to the read output; 0: the read returns the pre-write value.
- ZERO_REG, 0, 1: register 0 always reads 0 and writes to it are discarded.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- input_reg_readA_address  in  ADDR_W  read port A address.
- input_reg_readB_address  in  ADDR_W  read port B address.
- input_reg_write  in  1  write enable.
- input_reg_write_address  in  ADDR_W  write address.
- input_reg_write_value  in  DATA_W  write data.
- input_clear_start  in  1  single-cycle pulse that starts a clear of all registers.
- output_reg_A  out  DATA_W  registered read data, port A.
- output_reg_B  out  DATA_W  registered read data, port B.
- output_busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset, taking effect immediately on RST_N low:
  - All DEPTH registers go to 0.
  - output_reg_A and output_reg_B go to 0.
  - output_busy goes to 0; FSM goes to IDLE; clear pointer goes to 0.
  - Reset asserted mid-clear aborts the clear, and every register is 0 anyway.
- Read latency is 1 cycle. Addresses sampled at edge N appear on the outputs after edge N, stable until edge N+1.
- Reads operate every cycle in both FSM states; there is no read enable.
- Effective write at an edge: the external write in IDLE, or the sequencer's zero-write in CLEAR. At most one occurs per edge.
- BYPASS=1: if a read address equals the effective write address at the same edge, the output takes the written value.
- BYPASS=0: in the same case, the output takes the old array value.
- ZERO_REG=1: reads of address 0 always return 0, including bypass; writes to address 0 never change it.
- FSM states are IDLE and CLEAR.
- In IDLE:
  - input_clear_start=1 at an edge moves the FSM to CLEAR, sets pointer to 0 and output_busy to 1.
  - An external write sampled at that same edge is still performed.
- In CLEAR:
  - Each edge writes 0 to register[pointer], then the pointer increments.
  - At the edge where pointer = DEPTH-1, the FSM returns to IDLE and output_busy goes to 0.
  - output_busy is therefore high for exactly DEPTH cycles.
- External writes while output_busy=1 are dropped silently, including writes in the final CLEAR cycle.
- input_clear_start while output_busy=1 is ignored; it does not restart or extend the clear.
- Pointer wraps naturally at DEPTH; no overflow flag.
- All arithmetic is unsigned. Addresses are full-range with no out-of-range case.

Decomposition:
- Package rf_pkg:
  - state enum {RF_IDLE, RF_CLEAR}
  - default DATA_W/ADDR_W constants
  - RF_ZERO constant
- Sub-module rf_clear_seq: FSM, pointer, busy, and clear write-enable/address.
- The top module muxes the effective write and owns the array and read registers.

Test Plan:
- Reset then read: hold RST_N=0, then release; read A=3, B=5 -> both outputs 0x0000 after one edge, output_busy=0.
- Basic write/read: write 0xBEEF to reg 2; next cycle read A=2 -> output_reg_A=0xBEEF after the following edge.
- Bypass:
  - BYPASS=1: write 0x1234 to reg 4 with read B=4 in the same cycle -> output_reg_B=0x1234 after that edge.
  - BYPASS=0: same stimulus -> output_reg_B shows the old value (0x0000).
- ZERO_REG=1: write 0xFFFF to reg 0 -> reads of address 0 return 0x0000, and reg 1 is unchanged.
- Clear sequence:
  - Fill regs 0-7 with 0x1111*i, then pulse input_clear_start -> output_busy high for exactly 8 cycles.
  - A write of 0xAAAA to reg 6 issued mid-clear is dropped.
  - A second input_clear_start pulse mid-clear is ignored.
  - Afterwards all reads return 0x0000.
- Reset mid-clear: assert RST_N=0 at pointer=3 -> output_busy drops immediately and all registers read 0; a new clear pulse after release runs the full 8 cycles.
